// File: rtl/micro32_loader.sv
// micro32_loader: receives a framed byte stream and writes it into micro32
// instruction/data memory. It holds the CPU halted while loading and releases
// it with a start pulse once the frame checksum verifies.
//
// Frame: A5 | N[15:8] N[7:0] | B[15:8] B[7:0] | 4*N payload bytes | XOR checksum
//
// Ports
//   clk1       sole clock, rising edge
//   reset      synchronous, active-high
//   rx_data    incoming stream byte
//   rx_valid   rx_data valid
//   rx_ready   byte is accepted when rx_valid && rx_ready
//   mem_we     one-cycle word write strobe
//   mem_addr   word address of the write, (B + k) mod 2^ADDR_W
//   mem_wdata  assembled big-endian word
//   cpu_halt   keeps micro32 halted while high
//   cpu_start  one-cycle pulse releasing micro32 from PC 0
//   done       last frame loaded with a good checksum
//   err        sticky frame error, cleared only by reset
module micro32_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_halt,
  output logic              cpu_start,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    ADR_HI,
    ADR_LO,
    PAYLOAD,
    WRITE,
    CHECK,
    START,
    DONE,
    ERROR
  } state_t;

  // Largest legal word count is the full memory, 2^ADDR_W.
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;       // words still to be written
  logic [7:0]        adr_hi_q, adr_hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       asm_q, asm_d;
  logic [1:0]        nbyte_q, nbyte_d;
  logic [7:0]        csum_q, csum_d;

  logic        accept;
  logic [15:0] n16;
  logic [15:0] base16;
  logic        n_bad;

  assign accept = rx_valid && rx_ready;
  assign n16    = {cnt_q[15:8], rx_data};
  assign base16 = {adr_hi_q, rx_data};
  assign n_bad  = (n16 == 16'd0) || ({1'b0, n16} > MAX_N);

  assign mem_addr  = addr_q;
  assign mem_wdata = asm_q;

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      adr_hi_q <= '0;
      addr_q   <= '0;
      asm_q    <= '0;
      nbyte_q  <= '0;
      csum_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adr_hi_q <= adr_hi_d;
      addr_q   <= addr_d;
      asm_q    <= asm_d;
      nbyte_q  <= nbyte_d;
      csum_q   <= csum_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_hi_d  = adr_hi_q;
    addr_d    = addr_q;
    asm_d     = asm_q;
    nbyte_d   = nbyte_q;
    csum_d    = csum_q;
    rx_ready  = 1'b1;
    mem_we    = 1'b0;
    cpu_halt  = 1'b1;
    cpu_start = 1'b0;
    done      = 1'b0;
    err       = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          done     = 1'b1;
          cpu_halt = 1'b0;
        end
        // Anything other than the header byte is dropped here.
        if (accept && rx_data == 8'hA5) begin
          state_d = CNT_HI;
          csum_d  = '0;
          nbyte_d = '0;
        end
      end
      CNT_HI: begin
        if (accept) begin
          cnt_d[15:8] = rx_data;
          state_d     = CNT_LO;
        end
      end
      CNT_LO: begin
        if (accept) begin
          cnt_d   = n16;
          state_d = n_bad ? ERROR : ADR_HI;
        end
      end
      ADR_HI: begin
        if (accept) begin
          adr_hi_d = rx_data;
          state_d  = ADR_LO;
        end
      end
      ADR_LO: begin
        if (accept) begin
          addr_d  = base16[ADDR_W-1:0];
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          asm_d   = {asm_q[23:0], rx_data};
          csum_d  = csum_q ^ rx_data;
          nbyte_d = nbyte_q + 2'd1;
          if (nbyte_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        rx_ready = 1'b0;
        mem_we   = 1'b1;
        // Address advances after the strobe and wraps at 2^ADDR_W naturally.
        addr_d   = addr_q + ADDR_W'(1);
        cnt_d    = cnt_q - 16'd1;
        state_d  = (cnt_q == 16'd1) ? CHECK : PAYLOAD;
      end
      CHECK: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? START : ERROR;
        end
      end
      START: begin
        rx_ready  = 1'b0;
        cpu_start = 1'b1;
        cpu_halt  = 1'b0;
        state_d   = DONE;
      end
      ERROR: begin
        rx_ready = 1'b0;
        err      = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_micro32_loader.sv
module tb_micro32_loader;

  logic        clk1 = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_halt;
  logic        cpu_start;
  logic        done;
  logic        err;

  micro32_loader #(.ADDR_W(10)) dut (
    .clk1      (clk1),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_halt  (cpu_halt),
    .cpu_start (cpu_start),
    .done      (done),
    .err       (err)
  );

  always #5 clk1 = ~clk1;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned n_start = 0;
  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];

  logic [31:0] prog [8] = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                            32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};

  // Write/start log, sampled mid-cycle.
  always @(negedge clk1) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
    if (cpu_start) n_start++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b);
    int unsigned k = 0;
    @(negedge clk1);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && k < 20) begin
      @(negedge clk1);
      k++;
    end
    chk("accept_timeout", {31'd0, rx_ready}, 32'd1);
    @(posedge clk1);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic do_reset();
    @(negedge clk1);
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk1);
    #1 reset = 1'b0;
  endtask

  task automatic check_idle(input string p);
    chk({p, "_rx_ready"},  {31'd0, rx_ready},  32'd1);
    chk({p, "_mem_we"},    {31'd0, mem_we},    32'd0);
    chk({p, "_mem_addr"},  {22'd0, mem_addr},  32'd0);
    chk({p, "_mem_wdata"}, mem_wdata,          32'd0);
    chk({p, "_cpu_halt"},  {31'd0, cpu_halt},  32'd1);
    chk({p, "_cpu_start"}, {31'd0, cpu_start}, 32'd0);
    chk({p, "_done"},      {31'd0, done},      32'd0);
    chk({p, "_err"},       {31'd0, err},       32'd0);
  endtask

  initial begin
    int unsigned wb;
    int unsigned sb;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk1);
    #1 reset = 1'b0;
    check_idle("reset");

    // Good 8-word load to addresses 0..7, checksum 0x98.
    wb = wa_q.size();
    sb = n_start;
    send_byte(8'hA5);
    chk("hdr_halt", {31'd0, cpu_halt}, 32'd1);
    send_byte(8'h00); send_byte(8'h08); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 8; i++) begin
      send_word(prog[i]);
      chk("good_we",    {31'd0, mem_we},   32'd1);
      chk("good_addr",  {22'd0, mem_addr}, i);
      chk("good_wdata", mem_wdata,         prog[i]);
    end
    send_byte(8'h98);
    chk("good_start", {31'd0, cpu_start}, 32'd1);
    chk("good_start_halt", {31'd0, cpu_halt}, 32'd0);
    @(posedge clk1); #1;
    chk("good_done", {31'd0, done}, 32'd1);
    chk("good_done_halt", {31'd0, cpu_halt}, 32'd0);
    chk("good_start_once", {31'd0, cpu_start}, 32'd0);
    chk("good_nwrites", wa_q.size() - wb, 32'd8);
    chk("good_nstart", n_start - sb, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("good_log_addr", {22'd0, wa_q[wb + i]}, i);
      chk("good_log_data", wd_q[wb + i], prog[i]);
    end

    // Bad checksum, started straight from DONE: one write to 120 then ERROR.
    wb = wa_q.size();
    sb = n_start;
    send_byte(8'hA5);
    chk("bad_done_clr", {31'd0, done}, 32'd0);
    chk("bad_halt", {31'd0, cpu_halt}, 32'd1);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h78);
    send_word(32'h00000055);
    chk("bad_addr",  {22'd0, mem_addr}, 32'd120);
    chk("bad_wdata", mem_wdata,         32'h00000055);
    send_byte(8'hAA);
    chk("bad_err",      {31'd0, err},      32'd1);
    chk("bad_err_halt", {31'd0, cpu_halt}, 32'd1);
    chk("bad_err_rdy",  {31'd0, rx_ready}, 32'd0);
    @(negedge clk1);
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    repeat (4) @(negedge clk1);
    rx_valid = 1'b0;
    chk("bad_err_sticky", {31'd0, err}, 32'd1);
    chk("bad_nwrites", wa_q.size() - wb, 32'd1);
    chk("bad_nstart", n_start - sb, 32'd0);
    do_reset();
    check_idle("bad_rst");

    // Zero count.
    wb = wa_q.size();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    chk("zero_err", {31'd0, err}, 32'd1);
    repeat (3) @(posedge clk1);
    #1 chk("zero_nwrites", wa_q.size() - wb, 32'd0);
    do_reset();

    // Count 1025 exceeds memory; 1024 is accepted.
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    chk("n1025_err", {31'd0, err}, 32'd1);
    do_reset();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
    chk("n1024_err", {31'd0, err},      32'd0);
    chk("n1024_rdy", {31'd0, rx_ready}, 32'd1);
    do_reset();

    // Junk then wrap: base 0x3FF, writes to 1023 then 0, checksum 0x44.
    wb = wa_q.size();
    sb = n_start;
    send_byte(8'h3C); send_byte(8'h11);
    chk("junk_halt", {31'd0, cpu_halt}, 32'd1);
    chk("junk_rdy",  {31'd0, rx_ready}, 32'd1);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h03); send_byte(8'hFF);
    send_word(32'h11223344);
    chk("wrap_addr0", {22'd0, mem_addr}, 32'd1023);
    chk("wrap_data0", mem_wdata,         32'h11223344);
    send_word(32'ha5a5a5a5);
    chk("wrap_addr1", {22'd0, mem_addr}, 32'd0);
    chk("wrap_data1", mem_wdata,         32'ha5a5a5a5);
    send_byte(8'h44);
    chk("wrap_start", {31'd0, cpu_start}, 32'd1);
    @(posedge clk1); #1;
    chk("wrap_done", {31'd0, done}, 32'd1);
    chk("wrap_nwrites", wa_q.size() - wb, 32'd2);
    chk("wrap_nstart", n_start - sb, 32'd1);
    do_reset();

    // Stall mid-word, then reset during the second WRITE of a 4-word frame.
    wb = wa_q.size();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h0b); send_byte(8'had);
    @(negedge clk1);
    rx_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk1);
      chk("stall_rdy", {31'd0, rx_ready}, 32'd1);
      chk("stall_we",  {31'd0, mem_we},   32'd0);
    end
    send_byte(8'hf0); send_byte(8'h0d);
    chk("stall_we1",   {31'd0, mem_we},   32'd1);
    chk("stall_addr1", {22'd0, mem_addr}, 32'h10);
    chk("stall_data1", mem_wdata,         32'h0badf00d);
    send_word(32'h12345678);
    chk("stall_we2",   {31'd0, mem_we},   32'd1);
    chk("stall_addr2", {22'd0, mem_addr}, 32'h11);
    reset = 1'b1;
    @(posedge clk1);
    #1 reset = 1'b0;
    check_idle("midwr_rst");
    chk("midwr_nwrites", wa_q.size() - wb, 32'd2);
    send_byte(8'h9a); send_byte(8'hbc); send_byte(8'hde); send_byte(8'hf0);
    repeat (2) @(posedge clk1);
    #1;
    chk("post_rst_nwrites", wa_q.size() - wb, 32'd2);
    chk("post_rst_halt", {31'd0, cpu_halt}, 32'd1);
    chk("post_rst_done", {31'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
